// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: streams operands LSB-first through an external
// 1-bit slice and assembles the result, final carry/borrow and status flags.
module serial_alu_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             a_bit_o,
  output logic             b_bit_o,
  output logic             carry_o,
  output logic [2:0]       f_o,
  input  logic             result_bit_i,
  input  logic             carry_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_flag_o,
  output logic             zero_flag_o,
  output logic             error_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
  logic             cy_q, cy_d;
  logic [2:0]       op_d;
  logic [WIDTH-1:0] result_d;
  logic             cflag_d, zflag_d, error_d;
  logic             busy_d, done_d, a_bit_d, b_bit_d, carry_d;

  // Next-state and next-output decode; every output is registered from here.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    cy_d     = cy_q;
    op_d     = f_o;
    result_d = result_o;
    cflag_d  = carry_flag_o;
    zflag_d  = zero_flag_o;
    error_d  = error_o;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (op_i <= OP_SUB) begin
            a_sh_d   = a_i;
            b_sh_d   = b_i;
            op_d     = op_i;
            cnt_d    = '0;
            cy_d     = 1'b0;
            res_sh_d = '0;
            error_d  = 1'b0;
            state_d  = S_RUN;
          end else begin
            result_d = '0;
            error_d  = 1'b1;
            cflag_d  = 1'b0;
            zflag_d  = 1'b0;
            state_d  = S_DONE;
          end
        end
      end
      S_RUN: begin
        res_sh_d = {result_bit_i, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cy_d     = carry_i;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = res_sh_d;
          zflag_d  = (res_sh_d == '0);
          cflag_d  = ((f_o == OP_ADD) || (f_o == OP_SUB)) ? carry_i : 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
    a_bit_d = busy_d & a_sh_d[0];
    b_bit_d = busy_d & b_sh_d[0];
    carry_d = busy_d & cy_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      cy_q         <= 1'b0;
      f_o          <= 3'b000;
      result_o     <= '0;
      carry_flag_o <= 1'b0;
      zero_flag_o  <= 1'b0;
      error_o      <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      a_bit_o      <= 1'b0;
      b_bit_o      <= 1'b0;
      carry_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_sh_q     <= res_sh_d;
      cy_q         <= cy_d;
      f_o          <= op_d;
      result_o     <= result_d;
      carry_flag_o <= cflag_d;
      zero_flag_o  <= zflag_d;
      error_o      <= error_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      a_bit_o      <= a_bit_d;
      b_bit_o      <= b_bit_d;
      carry_o      <= carry_d;
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Bench for serial_alu_ctrl with a behavioural 1-bit slice, directed vectors,
// multi-cycle corner sequences and randomized operations against a word-level model.
module tb_serial_alu_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         a_bit, b_bit, cin, rbit, cout;
  logic [2:0]   f;
  logic         busy, done, cflag, zflag, err;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
    .a_i(a), .b_i(b), .a_bit_o(a_bit), .b_bit_o(b_bit), .carry_o(cin),
    .f_o(f), .result_bit_i(rbit), .carry_i(cout), .busy_o(busy),
    .done_o(done), .result_o(result), .carry_flag_o(cflag),
    .zero_flag_o(zflag), .error_o(err)
  );

  // External 1-bit slice: full adder / full subtractor / logic mux.
  always_comb begin
    rbit = 1'b0;
    cout = 1'b0;
    case (f)
      3'b000: rbit = a_bit & b_bit;
      3'b001: rbit = a_bit | b_bit;
      3'b010: rbit = a_bit ^ b_bit;
      3'b011: begin
        rbit = a_bit ^ b_bit ^ cin;
        cout = (a_bit & b_bit) | (cin & (a_bit ^ b_bit));
      end
      3'b100: begin
        rbit = a_bit ^ b_bit ^ cin;
        cout = (~a_bit & b_bit) | (cin & ~(a_bit ^ b_bit));
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         cf, zf, er;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word-level reference: plain arithmetic on whole operands.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c, output logic z, output logic e);
    logic [W:0] s;
    r = '0; c = 1'b0; e = 1'b0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: r = x ^ y;
      3'b011: begin s = {1'b0, x} + {1'b0, y}; r = s[W-1:0]; c = s[W]; end
      3'b100: begin r = x - y; c = (x < y); end
      default: e = 1'b1;
    endcase
    z = !e && (r == '0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic hold, input logic [W-1:0] er, input logic ec,
                        input logic ez, input logic ee);
    int k = 0;
    int busy_n = 0;
    bit got = 0;
    bit legal = (o <= 3'b100);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (!hold) start = 1'b0;
      if (busy) begin
        busy_n++;
        if (k <= int'(W)) begin
          chk("a_bit", 32'(a_bit), 32'(x[k-1]));
          chk("b_bit", 32'(b_bit), 32'(y[k-1]));
          chk("f_run", 32'(f), 32'(o));
        end
      end
      if (done) got = 1;
    end
    chk("latency", 32'(k), legal ? 32'(W + 1) : 32'd1);
    chk("busy_cycles", 32'(busy_n), legal ? 32'(W) : 32'd0);
    chk("result", 32'(result), 32'(er));
    chk("carry_flag", 32'(cflag), 32'(ec));
    chk("zero_flag", 32'(zflag), 32'(ez));
    chk("error", 32'(err), 32'(ee));
  endtask

  initial begin
    logic [W-1:0] r;
    logic c, z, e;
    logic [2:0] ro;
    int k;
    bit got;

    tbl[0] = '{3'b011, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{3'b100, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{3'b100, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{3'b010, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{3'b001, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{3'b110, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{3'b011, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{3'b011, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{3'b100, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({cflag, zflag, err}), 32'd0);
    chk("rst_slice", 32'({a_bit, b_bit, cin, f}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, tbl[i].res, tbl[i].cf, tbl[i].zf, tbl[i].er);

    @(negedge clk);
    chk("idle_slice", 32'({a_bit, b_bit, cin}), 32'd0);
    chk("idle_f_hold", 32'(f), 32'd4);

    // start held high: one operation, then a fresh one only after an IDLE cycle
    run_op(3'b011, 8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_idle_busy", 32'(busy), 32'd0);
    chk("hold_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("hold_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    k = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (done) got = 1;
    end
    chk("hold_second_done", 32'(got), 32'd1);
    chk("hold_second_result", 32'(result), 32'h02);

    // reset asserted while bit 3 is in flight
    @(negedge clk);
    op = 3'b011; a = 8'h0F; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) got = 1;
    end
    chk("post_rst_quiet", 32'(got), 32'd0);
    run_op(3'b011, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 7));
      a = W'($urandom);
      b = W'($urandom);
      if (i % 10 == 0) b = a;
      model(ro, a, b, r, c, z, e);
      run_op(ro, a, b, 1'b0, r, c, z, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  request a new operation; sampled only in IDLE.
REQ-005 op_i  input  `MUX_WIDTH  operation code: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB; 101-111 illegal.
REQ-006 a_i, b_i  input  WIDTH  operands; sampled with start_i.
REQ-007 a_bit_o, b_bit_o  output  1  current operand bits driven to the 1-bit ALU slice.
REQ-008 carry_o  output  1  carry-in (ADD) or borrow-in (SUB) to the slice.
REQ-009 f_o  output  `MUX_WIDTH  function select driven to the slice multiplexer.
REQ-010 result_bit_i  input  1  slice multiplexer output for the current bit.
REQ-011 carry_i  input  1  slice carry-out (ADD) or borrow-out (SUB).
REQ-012 busy_o  output  1  high in RUN.
REQ-013 done_o  output  1  one-cycle completion pulse.
REQ-014 result_o  output  WIDTH  assembled result.
REQ-015 carry_flag_o, zero_flag_o, error_o  output  1 each  final carry/borrow, result==0, illegal opcode.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-017 IDLE, start_i=1, legal op_i: latch a_i, b_i, op_i into shift registers and op register, clear bit counter and carry register, go to RUN.
REQ-018 IDLE, start_i=1, illegal op_i: go to DONE without RUN; result_o <= 0, error_o <= 1, carry_flag_o <= 0, zero_flag_o <= 0.
REQ-019 start_i is ignored in RUN and DONE; no queuing.
REQ-020 RUN: a_bit_o/b_bit_o = LSB of operand shift registers; carry_o = carry register; f_o = latched op; bits processed LSB first.
REQ-021 Each RUN cycle: shift result_bit_i into result register MSB end (shift right), shift operands right, carry register <= carry_i, counter++.
REQ-022 After WIDTH RUN cycles (counter == WIDTH-1 on current cycle) go to DONE; RUN lasts exactly WIDTH cycles.
REQ-023 DONE (one cycle): done_o=1, result_o = assembled result, zero_flag_o = (result==0), carry_flag_o = final carry register for ADD/SUB, 0 for logic ops; then IDLE.
REQ-024 Latency: start_i sampled at edge N, done_o high during cycle N+WIDTH+1 (illegal op: N+1).
REQ-025 result_o, flags, error_o hold their values until the next accepted start; error_o cleared on next legal start.
REQ-026 Initial carry/borrow-in is 0 for ADD and SUB; SUB computes a - b in two's complement, carry_flag_o = 1 on borrow (a < b unsigned).
REQ-027 Outside RUN: a_bit_o, b_bit_o, carry_o = 0; f_o holds latched op.
REQ-028 Counter width ceil(log2(WIDTH))+1; no wrap-around within an operation.

Reset
REQ-029 rst_n_i low forces IDLE immediately, regardless of state, including mid-RUN.
REQ-030 Reset values: busy_o 0, done_o 0, result_o 0, carry_flag_o 0, zero_flag_o 0, error_o 0, a_bit_o 0, b_bit_o 0, carry_o 0, f_o 000; counter, shift and carry registers 0.
REQ-031 First start_i accepted on the first rising edge after rst_n_i deasserts.

Verification (WIDTH=8, bench instantiates controller with the existing 1-bit slice and multiplexer)
REQ-032 ADD a=0xC8, b=0x64 -> done_o at start+9 cycles, result_o=0x2C, carry_flag_o=1, zero_flag_o=0, busy_o high exactly 8 cycles.
REQ-033 SUB a=0x05, b=0x07 -> result_o=0xFE, carry_flag_o=1; SUB a=0x07, b=0x05 -> result_o=0x02, carry_flag_o=0.
REQ-034 XOR a=0xAA, b=0xAA -> result_o=0x00, zero_flag_o=1, carry_flag_o=0; AND 0xF0/0x3C -> 0x30; OR 0xF0/0x0F -> 0xFF.
REQ-035 op_i=3'b110 with start_i -> done_o next cycle, error_o=1, result_o=0x00, busy_o never high; following legal ADD clears error_o.
REQ-036 start_i held high throughout ADD 0x01+0x01 -> single operation, result_o=0x02, new operation begins only from IDLE after done_o.
REQ-037 rst_n_i pulsed low during RUN bit 3 -> busy_o, done_o, result_o all 0 immediately, no done_o pulse, next start completes normally.
